collatz_sched: RTL and testbench

Round-robin scheduler that shares one Collatz iteration datapath among `N_REQ` requesters. Each requester hands over a start value through a valid/ready handshake. The block iterates that value to 1 one step per clock, counting the steps. It then returns the step count, tagged with the requester id, through a held response handshake. It sits between switch/button front-ends (or other producers) and LED or result sinks in the Collatz demo tops.

---
 rtl/collatz_sched.sv | 133 +++++++++++++
 tb/tb_collatz_sched.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/collatz_sched.sv
// Round-robin scheduler sharing one Collatz iteration datapath among N_REQ requesters.
// Each accepted start value is iterated to 1; the step count is returned tagged with the requester id.
module collatz_sched #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    localparam int ID_W = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_value,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [CNT_W-1:0]       resp_steps,
    output logic                   resp_err,
    output logic                   busy
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [CNT_W-1:0]  steps_q, steps_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic              err_q, err_d;
    logic              busy_q;

    logic [WIDTH-1:0]  val_w [N_REQ];
    logic              grant_vld;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   ptr_nxt;
    logic [WIDTH+1:0]  tri_w;
    logic              ovf_w;

    for (genvar g = 0; g < N_REQ; g++) begin : g_val
        assign val_w[g] = req_value[g*WIDTH +: WIDTH];
    end

    // First valid requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign ptr_nxt = (grant_id == ID_W'(N_REQ-1)) ? '0 : grant_id + 1'b1;

    // 3x+1 computed two bits wider so overflow is visible in the top bits.
    assign tri_w = ({2'b00, x_q} << 1) + {2'b00, x_q} + (WIDTH+2)'(1);
    assign ovf_w = |tri_w[WIDTH+1:WIDTH];

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        steps_d   = steps_q;
        id_d      = id_q;
        err_d     = err_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_vld && !rst) begin
                    req_ready[grant_id] = 1'b1;
                    x_d     = val_w[grant_id];
                    steps_d = '0;
                    id_d    = grant_id;
                    ptr_d   = ptr_nxt;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (x_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (x_q == WIDTH'(1)) begin
                    state_d = S_DONE;
                end else if ((x_q[0] && ovf_w) || (&steps_q)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    x_d     = x_q[0] ? tri_w[WIDTH-1:0] : (x_q >> 1);
                    steps_d = steps_q + 1'b1;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            steps_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            steps_q <= steps_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign resp_valid = (state_q == S_DONE);
    assign resp_id    = id_q;
    assign resp_steps = steps_q;
    assign resp_err   = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_collatz_sched.sv
// Scoreboard bench for collatz_sched: stimulus pushes expected responses, a monitor pops and compares.
module tb_collatz_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [63:0] req_value = 64'b0;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [1:0]  resp_id;
    logic [15:0] resp_steps;
    logic        resp_err;
    logic        busy;

    collatz_sched #(.N_REQ(4), .WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_steps(resp_steps), .resp_err(resp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int id; int steps; int err; int due;} exp_t;
    exp_t sb[$];
    int total = 0, bad = 0, cyc = 0, last_acc = 0;
    int exp_s[4], exp_e[4];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic setp(int p, int v, int s, int e);
        req_value[p*16 +: 16] = 16'(v);
        exp_s[p] = s;
        exp_e[p] = e;
    endtask

    task automatic push(int p);
        exp_t e;
        e.id = p; e.steps = exp_s[p]; e.err = exp_e[p]; e.due = cyc + 2 + exp_s[p];
        sb.push_back(e);
        last_acc = cyc;
    endtask

    task automatic wait_grant(output logic ok);
        int w;
        w = 0;
        ok = 1'b0;
        do begin
            @(negedge clk);
            w++;
        end while (req_ready == 4'b0 && w < 500);
        if (req_ready != 4'b0) ok = 1'b1;
        else begin
            total++; bad++;
            $display("FAIL grant_timeout actual=none required=a grant");
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 1000) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
        end
        #1;
    endtask

    // ord holds the expected grant sequence, two bits per grant, first grant in the low bits.
    task automatic grants(logic [3:0] mask, logic keep, int n, logic [7:0] ord);
        logic ok;
        int p;
        @(posedge clk); #1;
        req_valid = mask;
        for (int k = 0; k < n; k++) begin
            wait_grant(ok);
            if (!ok) break;
            p = int'(ord[2*k +: 2]);
            chk("grant", int'(req_ready), 1 << p);
            push(p);
            @(posedge clk); #1;
            if (!keep) req_valid[p] = 1'b0;
        end
        req_valid = 4'b0;
    endtask

    initial begin
        int first;
        logic pv;
        exp_t e;
        first = 0;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) pv = 1'b0;
            else begin
                if (resp_valid && !pv) first = cyc;
                if (resp_valid && resp_ready) begin
                    if (sb.size() == 0) begin
                        total++; bad++;
                        $display("FAIL resp_unexpected actual=id %0d required=no response", resp_id);
                    end else begin
                        e = sb.pop_front();
                        chk("resp_id", int'(resp_id), e.id);
                        chk("resp_steps", int'(resp_steps), e.steps);
                        chk("resp_err", int'(resp_err), e.err);
                        chk("resp_cycle", first, e.due);
                    end
                end
                pv = resp_valid;
            end
        end
    end

    initial begin
        logic ok;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_resp_id", int'(resp_id), 0);
        chk("rst_resp_steps", int'(resp_steps), 0);
        chk("rst_resp_err", int'(resp_err), 0);
        req_valid = 4'b0101;
        #1;
        chk("rst_req_ready", int'(req_ready), 0);
        req_valid = 4'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        // value 6 on port 0, response at t+10, busy drops at t+11
        setp(0, 6, 8, 0);
        grants(4'b0001, 1'b0, 1, 8'd0);
        do @(negedge clk); while (cyc < last_acc + 10);
        chk("busy_t10", int'(busy), 1);
        chk("valid_t10", int'(resp_valid), 1);
        @(negedge clk);
        chk("busy_t11", int'(busy), 0);
        chk("valid_t11", int'(resp_valid), 0);

        setp(2, 27, 111, 0);
        grants(4'b0100, 1'b0, 1, 8'd2);
        setp(3, 1, 0, 0);
        grants(4'b1000, 1'b0, 1, 8'd3);
        setp(0, 0, 0, 1);
        grants(4'b0001, 1'b0, 1, 8'd0);
        setp(1, 65535, 0, 1);
        grants(4'b0010, 1'b0, 1, 8'd1);
        setp(2, 32767, 0, 1);
        grants(4'b0100, 1'b0, 1, 8'd2);

        // fairness: port 3 alone, then all four, then 0/1 contending with 0 re-requesting
        for (int p = 0; p < 4; p++) setp(p, 1, 0, 0);
        grants(4'b1000, 1'b0, 1, 8'd3);
        grants(4'b1111, 1'b0, 4, 8'b11_10_01_00);
        grants(4'b0011, 1'b1, 3, 8'b00_00_01_00);

        // back-pressure with port 1 waiting
        wait_drain();
        resp_ready = 1'b0;
        setp(0, 3, 7, 0);
        grants(4'b0001, 1'b0, 1, 8'd0);
        setp(1, 7, 16, 0);
        req_valid[1] = 1'b1;
        do @(negedge clk); while (cyc < last_acc + 9);
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", int'(resp_valid), 1);
            chk("bp_id", int'(resp_id), 0);
            chk("bp_steps", int'(resp_steps), 7);
            chk("bp_err", int'(resp_err), 0);
            chk("bp_req_ready", int'(req_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        wait_grant(ok);
        if (ok) begin
            chk("bp_grant", int'(req_ready), 2);
            push(1);
        end
        @(posedge clk); #1;
        req_valid = 4'b0;

        // reset while port 1's job is running
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 4'b1010;
        sb.delete();
        #1;
        chk("mid_rst_valid", int'(resp_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_req_ready", int'(req_ready), 0);
        chk("mid_rst_id", int'(resp_id), 0);
        chk("mid_rst_steps", int'(resp_steps), 0);
        chk("mid_rst_err", int'(resp_err), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = 4'b0;
        setp(1, 7, 16, 0);
        setp(3, 1, 0, 0);
        grants(4'b1010, 1'b0, 2, 8'b0000_11_01);

        wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
